// File: rtl/mult_share_arbiter.sv
// Shares one combinational 16x16 signed multiplier between N_REQ requesters.
// Round-robin grant into an operand stage, then a registered result stage; valid/ready both sides.

module mult_16_16_top (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  localparam int unsigned PROD_W = 32;
  localparam int unsigned N_PP   = 8;

  logic [PROD_W-1:0] a_ext;
  logic [16:0]       b_ext;
  logic [2:0]        grp;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc;

  // Radix-4 Booth recoding: eight partial products in {0, +-A, +-2A}, summed mod 2^32
  always_comb begin
    a_ext = {{16{a[15]}}, a};
    b_ext = {b, 1'b0};
    grp   = '0;
    pp    = '0;
    acc   = '0;
    for (int i = 0; i < int'(N_PP); i++) begin
      grp = b_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    p = acc;
  end

endmodule

module mult_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_REQ-1:0]      REQ_VALID,
  output logic [N_REQ-1:0]      REQ_READY,
  input  logic [N_REQ*16-1:0]   REQ_A,
  input  logic [N_REQ*16-1:0]   REQ_B,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [31:0]           RES_DATA,
  output logic [ID_W-1:0]       RES_ID,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      OP_CNT
);

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;

  logic              s1_valid;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr;

  logic              s2_adv;
  logic              s1_adv;
  logic              s1_free;
  logic              found;
  logic              grant;
  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic [PROD_W-1:0] prod;

  always_comb begin
    s2_adv  = !RES_VALID || RES_READY;
    s1_adv  = s1_valid && s2_adv;
    s1_free = !s1_valid || s1_adv;
    BUSY    = s1_valid || RES_VALID;
  end

  // First valid requester at or after rr_ptr; grant is suppressed during reset
  always_comb begin
    found    = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % int'(N_REQ));
      if (!found && REQ_VALID[scan_idx]) begin
        found  = 1'b1;
        gnt_id = scan_idx;
      end
    end
    grant      = found && s1_free && !sys_rst;
    rr_ptr_nxt = ID_W'((int'(gnt_id) + 1) % int'(N_REQ));
    REQ_READY  = '0;
    if (grant) begin
      REQ_READY[gnt_id] = 1'b1;
    end
  end

  mult_16_16_top u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // Operand stage and round-robin pointer
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      s1_valid <= 1'b1;
      s1_a     <= REQ_A[OP_W*gnt_id +: OP_W];
      s1_b     <= REQ_B[OP_W*gnt_id +: OP_W];
      s1_id    <= gnt_id;
      rr_ptr   <= rr_ptr_nxt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result stage; data and id only load on advance so they hold under backpressure
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_ID    <= '0;
    end else if (s1_adv) begin
      RES_VALID <= 1'b1;
      RES_DATA  <= prod;
      RES_ID    <= s1_id;
    end else if (RES_VALID && RES_READY) begin
      RES_VALID <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      OP_CNT <= '0;
    end else if (RES_VALID && RES_READY) begin
      OP_CNT <= OP_CNT + CNT_W'(1);
    end
  end

endmodule
